cnt_seq_monitor: RTL and testbench

//  Sits directly downstream of the 3-bit sync up/down counter; samples its count
//  bus each clk. Checks every step against the enable/direction that produced it,

---
 rtl/cnt_pkg.sv | 6 +
 rtl/sat_ctr.sv | 18 +
 rtl/cnt_seq_monitor.sv | 138 +++++++++++++
 tb/tb_cnt_seq_monitor.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared types and defaults for the counter sequence monitor.
package cnt_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, TRACK, ERR} mon_state_t;
    localparam int CNT_W      = 3;
    localparam int STAT_W_DEF = 8;
endpackage

// File: rtl/sat_ctr.sv
// Saturating event counter with synchronous reset and clear.
module sat_ctr #(
    parameter int STAT_W = cnt_pkg::STAT_W_DEF
) (
    input  logic              clk,
    input  logic              res,
    input  logic              clr,
    input  logic              inc,
    output logic [STAT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (res || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {STAT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cnt_seq_monitor.sv
// Checks each step of an up/down counter against the enable/direction that
// produced it; reports lock, legal wraps, sequence errors and statistics.
//
// state | meaning
// IDLE  | first cycle after reset, only captures q/t/M
// SYNC  | counting consecutive good steps, errors never flagged
// TRACK | locked, mismatches are errors, wraps produce tc
// ERR   | error latched, waits for clr
module cnt_seq_monitor
    import cnt_pkg::*;
#(
    parameter int W        = CNT_W,
    parameter int SYNC_CYC = 2,
    parameter int STAT_W   = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              res,
    input  logic              t,
    input  logic              M,
    input  logic [W-1:0]      q,
    input  logic              clr,
    output logic              locked,
    output logic              tc,
    output logic              err,
    output logic [W-1:0]      bad_q,
    output logic [W-1:0]      bad_exp,
    output logic [STAT_W-1:0] wrap_cnt,
    output logic [STAT_W-1:0] err_cnt
);
    localparam int           MCNT_W = $clog2(SYNC_CYC + 1);
    localparam logic [W-1:0] Q_MAX  = {W{1'b1}};

    mon_state_t        state, state_nxt;
    logic [W-1:0]      q_d, exp_q;
    logic              t_d, m_d;
    logic [MCNT_W-1:0] mcnt, mcnt_nxt;
    logic              match, wrap, err_set, tc_nxt;

    // W-bit arithmetic wraps naturally between 0 and 2**W-1
    always_comb begin
        exp_q = q_d;
        if (t_d) begin
            exp_q = m_d ? (q_d - 1'b1) : (q_d + 1'b1);
        end
    end

    assign match = (q == exp_q);
    assign wrap  = t_d && match && (m_d ? (q_d == '0) : (q_d == Q_MAX));

    always_comb begin
        state_nxt = state;
        mcnt_nxt  = mcnt;
        err_set   = 1'b0;
        tc_nxt    = 1'b0;
        if (clr) begin
            mcnt_nxt = '0;
            if (state != IDLE) begin
                state_nxt = SYNC;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SYNC;
                    mcnt_nxt  = '0;
                end
                SYNC: begin
                    if (!match) begin
                        mcnt_nxt = '0;
                    end else if (mcnt == MCNT_W'(SYNC_CYC - 1)) begin
                        state_nxt = TRACK;
                        mcnt_nxt  = '0;
                    end else begin
                        mcnt_nxt = mcnt + 1'b1;
                    end
                end
                TRACK: begin
                    if (!match) begin
                        state_nxt = ERR;
                        err_set   = 1'b1;
                    end else begin
                        tc_nxt = wrap;
                    end
                end
                ERR:     state_nxt = ERR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state   <= IDLE;
            mcnt    <= '0;
            q_d     <= '0;
            t_d     <= 1'b0;
            m_d     <= 1'b0;
            locked  <= 1'b0;
            tc      <= 1'b0;
            err     <= 1'b0;
            bad_q   <= '0;
            bad_exp <= '0;
        end else begin
            state  <= state_nxt;
            mcnt   <= mcnt_nxt;
            q_d    <= q;
            t_d    <= t;
            m_d    <= M;
            locked <= (state_nxt == TRACK);
            tc     <= tc_nxt;
            if (clr) begin
                err     <= 1'b0;
                bad_q   <= '0;
                bad_exp <= '0;
            end else if (err_set) begin
                err     <= 1'b1;
                bad_q   <= q;
                bad_exp <= exp_q;
            end
        end
    end

    // counters advance on the same edge that raises tc / err
    sat_ctr #(.STAT_W(STAT_W)) u_wrap_ctr (
        .clk (clk),
        .res (res),
        .clr (clr),
        .inc (tc_nxt),
        .cnt (wrap_cnt)
    );

    sat_ctr #(.STAT_W(STAT_W)) u_err_ctr (
        .clk (clk),
        .res (res),
        .clr (clr),
        .inc (err_set),
        .cnt (err_cnt)
    );
endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Directed bench for cnt_seq_monitor: emulated counter stimulus, a step-rule
// model compared every cycle, plus literal expectations at key points.
`timescale 1ns/1ps
module tb_cnt_seq_monitor;
    localparam int W        = 3;
    localparam int SYNC_CYC = 2;
    localparam int MOD      = 1 << W;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         t   = 1'b1;
    logic         M   = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] q   = '0;

    logic         locked, tc, err, locked2, tc2, err2;
    logic [W-1:0] bad_q, bad_exp, bad_q2, bad_exp2;
    logic [7:0]   wrap_cnt, err_cnt;
    logic [1:0]   wrap_cnt2, err_cnt2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cnt_seq_monitor #(.W(W), .SYNC_CYC(SYNC_CYC), .STAT_W(8)) u_dut (
        .clk(clk), .res(res), .t(t), .M(M), .q(q), .clr(clr),
        .locked(locked), .tc(tc), .err(err), .bad_q(bad_q), .bad_exp(bad_exp),
        .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
    );

    cnt_seq_monitor #(.W(W), .SYNC_CYC(SYNC_CYC), .STAT_W(2)) u_dut2 (
        .clk(clk), .res(res), .t(t), .M(M), .q(q), .clr(clr),
        .locked(locked2), .tc(tc2), .err(err2), .bad_q(bad_q2), .bad_exp(bad_exp2),
        .wrap_cnt(wrap_cnt2), .err_cnt(err_cnt2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // model: phase 0 = fresh after reset, 1 = hunting, 2 = locked, 3 = faulted
    int prev_q = 0;
    bit prev_t = 1'b0, prev_m = 1'b0;
    int phase = 0, good_run = 0, n_wraps = 0, n_errs = 0;
    int m_bad_q = 0, m_bad_exp = 0;
    bit m_err = 1'b0, m_tc = 1'b0;
    int expv;
    bit ok, crossed;

    always @(posedge clk) begin
        if (res) begin
            phase = 0; good_run = 0; n_wraps = 0; n_errs = 0;
            m_bad_q = 0; m_bad_exp = 0; m_err = 1'b0; m_tc = 1'b0;
        end else begin
            expv    = (prev_q + (prev_t ? (prev_m ? MOD - 1 : 1) : 0)) % MOD;
            ok      = (int'(q) == expv);
            crossed = prev_t && ok && (prev_m ? (int'(q) > prev_q) : (int'(q) < prev_q));
            m_tc    = 1'b0;
            if (clr) begin
                good_run = 0; n_wraps = 0; n_errs = 0;
                m_bad_q = 0; m_bad_exp = 0; m_err = 1'b0;
                if (phase != 0) phase = 1;
            end else if (phase == 0) begin
                phase = 1; good_run = 0;
            end else if (phase == 1) begin
                good_run = ok ? good_run + 1 : 0;
                if (good_run >= SYNC_CYC) phase = 2;
            end else if (phase == 2) begin
                if (!ok) begin
                    phase = 3; m_err = 1'b1; m_bad_q = int'(q); m_bad_exp = expv;
                    n_errs++;
                end else if (crossed) begin
                    m_tc = 1'b1; n_wraps++;
                end
            end
        end
        prev_q = int'(q); prev_t = t; prev_m = M;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",    int'(locked),    int'(phase == 2));
            check("tc",        int'(tc),        int'(m_tc));
            check("err",       int'(err),       int'(m_err));
            check("bad_q",     int'(bad_q),     m_bad_q);
            check("bad_exp",   int'(bad_exp),   m_bad_exp);
            check("wrap_cnt",  int'(wrap_cnt),  sat(n_wraps, 255));
            check("err_cnt",   int'(err_cnt),   sat(n_errs, 255));
            check("locked2",   int'(locked2),   int'(phase == 2));
            check("err2",      int'(err2),      int'(m_err));
            check("wrap_cnt2", int'(wrap_cnt2), sat(n_wraps, 3));
            check("err_cnt2",  int'(err_cnt2),  sat(n_errs, 3));
        end
    end

    // one clock; the emulated counter then steps with the t/M it was sampled with
    task automatic tick();
        @(posedge clk);
        #1;
        if (t) q = M ? q - 1'b1 : q + 1'b1;
    endtask

    task automatic run_to(input int v);
        int n = 0;
        while (int'(q) != v && n < 2 * MOD) begin
            tick();
            n++;
        end
        check("run_to", int'(q), v);
    endtask

    int tc_seen;
    int n;

    initial begin
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        check("rst_locked", int'(locked), 0);
        check("rst_wrap", int'(wrap_cnt), 0);
        check("rst_err", int'(err), 0);

        // free-running up count
        tick(); tick();
        check("lit_unlocked_e1", int'(locked), 0);
        tick();
        check("lit_locked_e2", int'(locked), 1);
        repeat (22) tick();
        check("lit_wrap3", int'(wrap_cnt), 3);
        check("lit_wrap3_sat2", int'(wrap_cnt2), 3);
        check("lit_tc_e24", int'(tc), 1);
        check("lit_err_up", int'(err), 0);

        // down count with a mid-run direction toggle
        tc_seen = 0;
        M = 1'b1;
        repeat (8) begin tick(); tc_seen += int'(tc); end
        M = 1'b0;
        repeat (2) begin tick(); tc_seen += int'(tc); end
        M = 1'b1;
        repeat (7) begin tick(); tc_seen += int'(tc); end
        check("lit_tc_down", tc_seen, 2);
        check("lit_wrap5", int'(wrap_cnt), 5);
        check("lit_err_down", int'(err), 0);
        check("lit_locked_down", int'(locked), 1);

        // glitch while tracking up at q=2
        M = 1'b0;
        run_to(2);
        tick();
        q = 3'd5;
        tick();
        check("lit_glitch_err", int'(err), 1);
        check("lit_glitch_bad_q", int'(bad_q), 5);
        check("lit_glitch_bad_exp", int'(bad_exp), 3);
        check("lit_glitch_err_cnt", int'(err_cnt), 1);
        check("lit_glitch_locked", int'(locked), 0);
        q = q + 3'd2;
        tick();
        check("lit_glitch2_err_cnt", int'(err_cnt), 1);

        // clr out of ERR, relock
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("lit_clr_err", int'(err), 0);
        check("lit_clr_err_cnt", int'(err_cnt), 0);
        check("lit_clr_wrap", int'(wrap_cnt), 0);
        check("lit_clr_bad_exp", int'(bad_exp), 0);
        tick();
        check("lit_clr_sync", int'(locked), 0);
        tick();
        check("lit_clr_relock", int'(locked), 1);

        // hold with t=0, then an illegal step while disabled
        run_to(4);
        t = 1'b0;
        repeat (3) tick();
        check("lit_hold_err", int'(err), 0);
        check("lit_hold_locked", int'(locked), 1);
        q = 3'd5;
        tick();
        check("lit_t0_err", int'(err), 1);
        check("lit_t0_bad_q", int'(bad_q), 5);
        check("lit_t0_bad_exp", int'(bad_exp), 4);

        // clr coincident with a glitch in TRACK
        t = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick();
        check("lit_relock2", int'(locked), 1);
        clr = 1'b1;
        q = q + 3'd3;
        tick();
        clr = 1'b0;
        check("lit_clrglitch_err", int'(err), 0);
        check("lit_clrglitch_err_cnt", int'(err_cnt), 0);
        check("lit_clrglitch_locked", int'(locked), 0);
        tick(); tick();
        check("lit_relock3", int'(locked), 1);

        // reset pulse while locked with three wraps counted
        n = 0;
        while (n_wraps < 3 && n < 40) begin tick(); n++; end
        check("lit_pre_res_wrap", int'(wrap_cnt), 3);
        res = 1'b1;
        @(posedge clk);
        #1;
        res = 1'b0;
        q = '0;
        check("lit_res_locked", int'(locked), 0);
        check("lit_res_tc", int'(tc), 0);
        check("lit_res_wrap", int'(wrap_cnt), 0);
        check("lit_res_err_cnt", int'(err_cnt), 0);
        check("lit_res_bad_q", int'(bad_q), 0);
        tick(); tick();
        check("lit_res_sync", int'(locked), 0);
        tick();
        check("lit_res_relock", int'(locked), 1);

        // saturation of the narrow instance
        n = 0;
        while (n_wraps < 5 && n < 60) begin tick(); n++; end
        check("lit_sat_wrap8", int'(wrap_cnt), 5);
        check("lit_sat_wrap2", int'(wrap_cnt2), 3);

        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
